// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing control slice.
//   state_e   : sequencing FSM states
//   FWD_*     : EX operand forwarding select encodings
//   REG_ZERO  : architectural zero register (never hazards / forwards)
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/forward_select.sv
// Operand forwarding select for one source register.
//   src_i                  : source register field from ID
//   ex_rd_i/ex_reg_we_i/ex_load_i : EX-stage producer (loads cannot forward from EX)
//   mem_rd_i/mem_reg_we_i  : MEM-stage producer
//   wb_rd_i/wb_reg_we_i    : WB-stage producer
//   sel_o                  : FWD_RF / FWD_EX / FWD_MEM / FWD_WB, youngest producer wins
module forward_select
    import core_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_reg_we_i,
    input  logic                  ex_load_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_reg_we_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_reg_we_i,
    output logic [1:0]            sel_o
);

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(REG_ZERO);

    always_comb begin
        sel_o = FWD_RF;
        if (src_i != ZERO_ADDR) begin
            if (ex_reg_we_i && !ex_load_i && (ex_rd_i == src_i)) begin
                sel_o = FWD_EX;
            end else if (mem_reg_we_i && (mem_rd_i == src_i)) begin
                sel_o = FWD_MEM;
            end else if (wb_reg_we_i && (wb_rd_i == src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage core.
// Flushes the pipe after reset, inserts a bubble on load-use hazards, freezes
// every pipeline register while data memory is not ready (halting after too
// many consecutive not-ready cycles), and generates EX forwarding selects.
//   clk, reset_n              : clock, async active-low reset
//   id_*                      : source fields / usage of the ID instruction
//   ex_*, mem_*, wb_*         : producers in later stages, memory handshake
//   pc_le .. memwb_le         : pipeline register load enables (Mealy)
//   cmux                      : 1 = zero ID control signals (bubble)
//   fwd_a, fwd_b              : rs / rt operand forwarding selects
//   halted                    : memory timeout flag, cleared only by reset
//   stall_cycles              : saturating count of cycles with pc_le=0
module hazard_stall_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned INIT_CYCLES  = 2,
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   ex_reg_we,
    input  logic                   ex_load,
    input  logic [REG_ADDR_W-1:0]  mem_rd,
    input  logic                   mem_reg_we,
    input  logic                   mem_access,
    input  logic                   dmem_ready,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  logic                   wb_reg_we,
    output logic                   pc_le,
    output logic                   ifid_le,
    output logic                   idex_le,
    output logic                   exmem_le,
    output logic                   memwb_le,
    output logic                   cmux,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(REG_ZERO);
    localparam logic [3:0]            INIT_LAST = 4'(INIT_CYCLES - 1);
    localparam logic [7:0]            WAIT_MAX  = 8'(MEM_WAIT_MAX);

    state_e                 state_q, state_d;
    logic [3:0]             init_cnt_q, init_cnt_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic mem_stall;
    logic run_rules;

    assign mem_stall = mem_access & ~dmem_ready;
    assign load_use  = ex_load & ex_reg_we & (ex_rd != ZERO_ADDR) &
                       ((id_uses_rs & (id_rs == ex_rd)) |
                        (id_uses_rt & (id_rt == ex_rd)));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + 4'd1;
                if (init_cnt_q == INIT_LAST) state_d = RUN;
            end
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q < WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end else begin
                    state_d = HALT;
                end
            end
            HALT: state_d = HALT;
            default: state_d = INIT;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (!pc_le && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Output logic: the MEM_WAIT release cycle reuses the RUN hazard rules
    always_comb begin
        pc_le     = 1'b0;
        ifid_le   = 1'b0;
        idex_le   = 1'b0;
        exmem_le  = 1'b0;
        memwb_le  = 1'b0;
        cmux      = 1'b0;
        run_rules = 1'b0;
        unique case (state_q)
            INIT: begin
                idex_le  = 1'b1;
                exmem_le = 1'b1;
                memwb_le = 1'b1;
                cmux     = 1'b1;
            end
            RUN:      run_rules = ~mem_stall;
            MEM_WAIT: run_rules = dmem_ready;
            HALT:     cmux = 1'b1;
            default:  cmux = 1'b1;
        endcase
        if (run_rules) begin
            pc_le    = ~load_use;
            ifid_le  = ~load_use;
            idex_le  = 1'b1;
            exmem_le = 1'b1;
            memwb_le = 1'b1;
            cmux     = load_use;
        end
    end

    assign halted       = (state_q == HALT);
    assign stall_cycles = stall_cnt_q;

    forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src_i        (id_rs),
        .ex_rd_i      (ex_rd),
        .ex_reg_we_i  (ex_reg_we),
        .ex_load_i    (ex_load),
        .mem_rd_i     (mem_rd),
        .mem_reg_we_i (mem_reg_we),
        .wb_rd_i      (wb_rd),
        .wb_reg_we_i  (wb_reg_we),
        .sel_o        (fwd_a)
    );

    forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src_i        (id_rt),
        .ex_rd_i      (ex_rd),
        .ex_reg_we_i  (ex_reg_we),
        .ex_load_i    (ex_load),
        .mem_rd_i     (mem_rd),
        .mem_reg_we_i (mem_reg_we),
        .wb_rd_i      (wb_rd),
        .wb_reg_we_i  (wb_reg_we),
        .sel_o        (fwd_b)
    );

endmodule
